// File: rtl/kb_pkg.sv
// kb_pkg: PS/2 set-2 protocol bytes and decoder state type shared by the keyboard event queue
package kb_pkg;
  localparam logic [7:0] KB_E0     = 8'hE0;
  localparam logic [7:0] KB_F0     = 8'hF0;
  localparam logic [7:0] KB_ACK    = 8'hFA;
  localparam logic [7:0] KB_BAT    = 8'hAA;
  localparam logic [7:0] KB_ECHO   = 8'hEE;
  localparam logic [7:0] KB_RESEND = 8'hFE;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kb_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 FIFO with inferred RAM and show-ahead (head visible without a read) output
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic             w_pop, w_push;
  assign empty  = r_count == '0;
  assign full   = r_count == CW'(DEPTH);
  assign w_pop  = pop && !empty;
  // a pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd];
  assign count  = r_count;
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wr] <= din;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/kb_event_fifo.sv
// kb_event_fifo: decodes PS/2 set-2 bytes into make/break events and queues them for the CPU
module kb_event_fifo import kb_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int TRACK_E0 = 1,
  parameter int DROP_RELEASE = 0,
  localparam int EVW = 8 + TRACK_E0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [7:0]     ps2_data,
  input  logic           ps2_data_en,
  input  logic [7:0]     key_ascii,
  input  logic           kb_pop,
  input  logic           kb_ovf_clr,
  output logic [EVW-1:0] kb_ch,
  output logic           kb_hit,
  output logic [CW-1:0]  kb_count,
  output logic           kb_ovf
);
  kb_state_t      r_state;
  logic           r_ovf;
  logic           w_reply, w_emit, w_brk, w_e0, w_push, w_full, w_empty, w_drop;
  logic [7:0]     w_low;
  logic [EVW-1:0] w_ev, w_dout;
  assign w_reply = ps2_data inside {KB_ACK, KB_BAT, KB_ECHO, KB_RESEND};
  assign w_brk   = r_state inside {BRK, EXT_BRK};
  assign w_e0    = r_state inside {EXT, EXT_BRK};
  // E0 and F0 only extend an open prefix; E0 after E0+F0 and F0 after a bare F0 are key codes
  assign w_emit  = ps2_data_en && !w_reply && !(ps2_data == KB_E0 && r_state != EXT_BRK)
                   && !(ps2_data == KB_F0 && r_state != BRK);
  assign w_low   = key_ascii[7:4] == 4'hE ? key_ascii : {w_brk, key_ascii[6:0]};
  assign w_ev    = EVW'({w_e0, w_low});
  assign w_push  = w_emit && !(DROP_RELEASE != 0 && w_brk);
  assign w_drop  = w_push && w_full && !kb_pop;
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else if (ps2_data_en && !w_reply)
      r_state <= w_emit ? IDLE : ps2_data == KB_E0 ? (w_brk ? EXT_BRK : EXT) : (w_e0 ? EXT_BRK : BRK);
  end
  always_ff @(posedge clock)
    r_ovf <= !reset_n ? 1'b0 : w_drop ? 1'b1 : kb_ovf_clr ? 1'b0 : r_ovf;
  sync_fifo #(.WIDTH(EVW), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (kb_pop),
    .din     (w_ev),
    .dout    (w_dout),
    .count   (kb_count),
    .full    (w_full),
    .empty   (w_empty)
  );
  assign kb_ch  = w_empty ? '0 : w_dout;
  assign kb_hit = !w_empty;
  assign kb_ovf = r_ovf;
endmodule

// File: tb/tb_kb_event_fifo.sv
// tb_kb_event_fifo: random and directed stimulus against a queue-based reference of the event queue
module tb_kb_event_fifo;
  localparam int DEPTH = 16;
  logic       clock = 0, reset_n = 0, ps2_data_en = 0, kb_pop = 0, kb_ovf_clr = 0;
  logic [7:0] ps2_data = 0, key_ascii = 0;
  logic [8:0] ch0, ch1;
  logic [4:0] cnt0, cnt1;
  logic       hit0, hit1, ovf0, ovf1;
  logic       run = 0;
  int         n_chk = 0, n_pass = 0;
  logic [8:0] q0[$], q1[$];
  logic       m_e0 = 0, m_brk = 0, m_ovf0 = 0, m_ovf1 = 0;
  logic [7:0] rep[4] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE};

  always #5 clock = ~clock;

  kb_event_fifo u_keep (
    .clock(clock), .reset_n(reset_n), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .key_ascii(key_ascii), .kb_pop(kb_pop), .kb_ovf_clr(kb_ovf_clr),
    .kb_ch(ch0), .kb_hit(hit0), .kb_count(cnt0), .kb_ovf(ovf0));
  kb_event_fifo #(.DROP_RELEASE(1)) u_drop (
    .clock(clock), .reset_n(reset_n), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .key_ascii(key_ascii), .kb_pop(kb_pop), .kb_ovf_clr(kb_ovf_clr),
    .kb_ch(ch1), .kb_hit(hit1), .kb_count(cnt1), .kb_ovf(ovf1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: prefix flags e0/brk, then pop-before-push on plain queues
  always @(posedge clock) begin
    logic       emit, eb, ee, d0, d1;
    logic [7:0] lo;
    logic [8:0] ev;
    if (!reset_n) begin
      q0.delete(); q1.delete();
      m_e0 = 0; m_brk = 0; m_ovf0 = 0; m_ovf1 = 0;
    end else begin
      emit = 0; eb = m_brk; ee = m_e0; d0 = 0; d1 = 0;
      if (ps2_data_en && !(ps2_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE})) begin
        if (ps2_data == 8'hE0 && !(m_brk && m_e0)) m_e0 = 1;
        else if (ps2_data == 8'hF0 && !(m_brk && !m_e0)) m_brk = 1;
        else begin emit = 1; m_e0 = 0; m_brk = 0; end
      end
      lo = key_ascii[7:4] == 4'hE ? key_ascii : {eb, key_ascii[6:0]};
      ev = {ee, lo};
      if (kb_pop && q0.size() > 0) void'(q0.pop_front());
      if (kb_pop && q1.size() > 0) void'(q1.pop_front());
      if (emit) begin
        if (q0.size() < DEPTH) q0.push_back(ev); else d0 = 1;
        if (!eb) begin
          if (q1.size() < DEPTH) q1.push_back(ev); else d1 = 1;
        end
      end
      m_ovf0 = d0 ? 1'b1 : kb_ovf_clr ? 1'b0 : m_ovf0;
      m_ovf1 = d1 ? 1'b1 : kb_ovf_clr ? 1'b0 : m_ovf1;
    end
  end

  always @(negedge clock) if (run) begin
    chk("count", cnt0, q0.size());
    chk("hit", hit0, q0.size() > 0);
    chk("head", ch0, q0.size() > 0 ? q0[0] : 9'h0);
    chk("ovf", ovf0, m_ovf0);
    chk("drop_count", cnt1, q1.size());
    chk("drop_hit", hit1, q1.size() > 0);
    chk("drop_head", ch1, q1.size() > 0 ? q1[0] : 9'h0);
    chk("drop_ovf", ovf1, m_ovf1);
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask
  task automatic send(input logic [7:0] d, input logic [7:0] a);
    ps2_data = d; key_ascii = a; ps2_data_en = 1;
    tick();
    ps2_data_en = 0;
  endtask
  task automatic pop();
    kb_pop = 1; tick(); kb_pop = 0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset_n = 1; run = 1;
    chk("rst_count", cnt0, 0);
    chk("rst_hit", hit0, 0);
    chk("rst_ch", ch0, 0);
    chk("rst_ovf", ovf0, 0);
    send(8'h1C, 8'h61);
    chk("t1_ch", ch0, 9'h061);
    chk("t1_hit", hit0, 1);
    chk("t1_count", cnt0, 1);
    chk("t1_model", q0[0], 9'h061);
    pop();
    chk("t1_pop_hit", hit0, 0);
    chk("t1_pop_ch", ch0, 0);
    send(8'hF0, 8'h00); send(8'h1C, 8'h61);
    chk("t2_brk", ch0, 9'h0E1);
    chk("t2_drop_cnt", cnt1, 0);
    pop();
    send(8'hE0, 8'h00); send(8'hF0, 8'h00); send(8'h75, 8'hE2);
    chk("t2_ebrk", ch0, 9'h1E2);
    chk("t2_drop_cnt2", cnt1, 0);
    pop();
    for (int i = 0; i < DEPTH; i++) send(8'h16, 8'(8'h30 + i));
    chk("t3_full_ovf", ovf0, 0);
    send(8'h16, 8'h50);
    chk("t3_count", cnt0, 16);
    chk("t3_ovf", ovf0, 1);
    chk("t3_head", ch0, 9'h030);
    kb_pop = 1; send(8'h16, 8'h41); kb_pop = 0;
    chk("t3_pp_count", cnt0, 16);
    chk("t3_pp_head", ch0, 9'h031);
    kb_ovf_clr = 1; send(8'h16, 8'h42); kb_ovf_clr = 0;
    chk("t4_set_wins", ovf0, 1);
    kb_ovf_clr = 1; tick(); kb_ovf_clr = 0;
    chk("t4_clr", ovf0, 0);
    repeat (DEPTH) pop();
    chk("t4_drain", cnt0, 0);
    send(8'hE0, 8'h00); send(8'hFA, 8'h00); send(8'hAA, 8'h00); send(8'h6B, 8'h34);
    chk("t5_count", cnt0, 1);
    chk("t5_ch", ch0, 9'h134);
    pop(); pop();
    chk("t5_underflow", cnt0, 0);
    for (int i = 0; i < 5; i++) send(8'h1C, 8'h61);
    send(8'hE0, 8'h00);
    reset_n = 0; tick(); reset_n = 1;
    chk("t6_count", cnt0, 0);
    chk("t6_hit", hit0, 0);
    send(8'h1C, 8'h61);
    chk("t6_plain", ch0, 9'h061);
    pop();
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 9))
        0, 1:    ps2_data = 8'hE0;
        2, 3:    ps2_data = 8'hF0;
        4:       ps2_data = rep[$urandom_range(0, 3)];
        default: ps2_data = 8'($urandom);
      endcase
      key_ascii   = $urandom_range(0, 3) == 0 ? {4'hE, 4'($urandom)} : 8'($urandom);
      ps2_data_en = $urandom_range(0, 1) == 1;
      kb_pop      = $urandom_range(0, 4) == 0;
      kb_ovf_clr  = $urandom_range(0, 19) == 0;
      reset_n     = $urandom_range(0, 299) != 0;
      tick();
    end
    ps2_data_en = 0; kb_pop = 0; kb_ovf_clr = 0; reset_n = 1;
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
